// File: rtl/calc1_req_sequencer.sv
// Request sequencer for one calc1 port: queues commands, drives the two-cycle calc1 request, returns the response.
// Optional CALC1_SEQ_TIMEOUT_EN adds a WAIT_RESP timeout of TIMEOUT_CYC cycles; otherwise rsp_timeout is tied to 0.
module calc1_req_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_cmd,
    input  logic [31:0]                   req_data1,
    input  logic [31:0]                   req_data2,
    output logic [3:0]                    calc_cmd_out,
    output logic [31:0]                   calc_data_out,
    input  logic [1:0]                    calc_resp_in,
    input  logic [31:0]                   calc_data_in,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_code,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND_OP1  = 3'd1;
    localparam logic [2:0] S_SEND_OP2  = 3'd2;
    localparam logic [2:0] S_WAIT_RESP = 3'd3;
    localparam logic [2:0] S_HOLD_RSP  = 3'd4;

    logic [2:0]    state;
    logic [3:0]    fifo_cmd [FIFO_DEPTH];
    logic [31:0]   fifo_d1  [FIFO_DEPTH];
    logic [31:0]   fifo_d2  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [3:0]    head_cmd;
    logic [31:0]   head_d1;
    logic [31:0]   head_d2;
    logic [31:0]   op2_q;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head_cmd   = fifo_cmd[rd_ptr];
    assign head_d1    = fifo_d1[rd_ptr];
    assign head_d2    = fifo_d2[rd_ptr];
    assign busy       = (state != S_IDLE);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr] <= req_cmd;
            fifo_d1[wr_ptr]  <= req_data1;
            fifo_d2[wr_ptr]  <= req_data2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef CALC1_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wait_cnt;
    logic          timeout_q;
    logic          expire;

    // A response on the expiry cycle wins, so expiry only fires with calc_resp_in idle.
    assign expire = (state == S_WAIT_RESP) && (calc_resp_in == 2'd0) &&
                    (wait_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_SEND_OP2)
                wait_cnt <= '0;
            else if (state == S_WAIT_RESP)
                wait_cnt <= wait_cnt + TW'(1);
            if (expire)
                timeout_q <= 1'b1;
            else if (state == S_HOLD_RSP && rsp_ready)
                timeout_q <= 1'b0;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            calc_cmd_out  <= '0;
            calc_data_out <= '0;
            op2_q         <= '0;
            rsp_valid     <= 1'b0;
            rsp_code      <= '0;
            rsp_data      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_cmd != 4'd0) begin
                            state         <= S_SEND_OP1;
                            calc_cmd_out  <= head_cmd;
                            calc_data_out <= head_d1;
                            op2_q         <= head_d2;
                        end else begin
                            // Null command is answered locally as invalid without touching the bus.
                            state     <= S_HOLD_RSP;
                            rsp_valid <= 1'b1;
                            rsp_code  <= 2'd3;
                            rsp_data  <= '0;
                        end
                    end
                end
                S_SEND_OP1: begin
                    state         <= S_SEND_OP2;
                    calc_cmd_out  <= '0;
                    calc_data_out <= op2_q;
                end
                S_SEND_OP2: begin
                    state         <= S_WAIT_RESP;
                    calc_data_out <= '0;
                end
                S_WAIT_RESP: begin
                    if (calc_resp_in != 2'd0) begin
                        state     <= S_HOLD_RSP;
                        rsp_valid <= 1'b1;
                        rsp_code  <= calc_resp_in;
                        rsp_data  <= calc_data_in;
                    end
`ifdef CALC1_SEQ_TIMEOUT_EN
                    else if (expire) begin
                        state     <= S_HOLD_RSP;
                        rsp_valid <= 1'b1;
                        rsp_code  <= '0;
                        rsp_data  <= '0;
                    end
`endif
                end
                S_HOLD_RSP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_req_sequencer.sv
// Scoreboard bench for calc1_req_sequencer: random requests, a calc1 responder model and a response monitor.
module tb_calc1_req_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_data1;
    logic [31:0] req_data2;
    logic [3:0]  calc_cmd_out;
    logic [31:0] calc_data_out;
    logic [1:0]  calc_resp_in;
    logic [31:0] calc_data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  fifo_count;

    logic [1:0]  resp_drv;
    bit          stray_en = 1'b0;
    bit          hang     = 1'b0;
    bit          stall    = 1'b0;
    bit          squash   = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic        to;
        logic [1:0]  code;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] d1;
        logic [31:0] d2;
    } bus_t;

    rsp_t exp_q[$];
    bus_t bus_q[$];

    assign calc_resp_in = stray_en ? 2'd1 : resp_drv;

    always #5 clk = ~clk;

    calc1_req_sequencer #(
        .FIFO_DEPTH (4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_data1    (req_data1),
        .req_data2    (req_data2),
        .calc_cmd_out (calc_cmd_out),
        .calc_data_out(calc_data_out),
        .calc_resp_in (calc_resp_in),
        .calc_data_in (calc_data_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_code     (rsp_code),
        .rsp_data     (rsp_data),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // calc1 behaviour as seen by the sequencer: add/sub flag carry/borrow, shifts always ok, rest invalid.
    function automatic rsp_t calc_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        rsp_t        r;
        logic [32:0] s;
        r.to = 1'b0;
        case (c)
            4'd1: begin
                s      = {1'b0, a} + {1'b0, b};
                r.data = s[31:0];
                r.code = s[32] ? 2'd2 : 2'd1;
            end
            4'd2: begin
                r.data = a - b;
                r.code = (b > a) ? 2'd2 : 2'd1;
            end
            4'd5: begin
                r.data = a << b[4:0];
                r.code = 2'd1;
            end
            4'd6: begin
                r.data = a >> b[4:0];
                r.code = 2'd1;
            end
            default: begin
                r.data = 32'd0;
                r.code = 2'd3;
            end
        endcase
        return r;
    endfunction

    function automatic logic [3:0] pick_cmd();
        case ($urandom_range(0, 7))
            0:       return 4'd0;
            1, 2:    return 4'd1;
            3:       return 4'd2;
            4:       return 4'd5;
            5:       return 4'd6;
            6:       return 4'd3;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'd0;
            2:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic push_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        rsp_t        e;
        bus_t        be;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = c;
        req_data1 = a;
        req_data2 = b;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 96'(req_ready), 96'(1));
        if (req_ready) begin
            e = calc_model(c, a, b);
`ifdef CALC1_SEQ_TIMEOUT_EN
            if (hang && c != 4'd0) begin
                e.to   = 1'b1;
                e.code = 2'd0;
                e.data = 32'd0;
            end
`endif
            exp_q.push_back(e);
            if (c != 4'd0) begin
                be.cmd = c;
                be.d1  = a;
                be.d2  = b;
                bus_q.push_back(be);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd   = 4'($urandom);
        req_data1 = $urandom;
        req_data2 = $urandom;
    endtask

    task automatic wait_drain(input string name);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || busy || fifo_count != 3'd0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 96'(n < 3000), 96'(1));
    endtask

    // calc1 responder: checks bus traffic against the issued requests and answers after a random delay.
    initial begin
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        bus_t        be;
        bit          have;
        rsp_t        r;
        resp_drv     = 2'd0;
        calc_data_in = $urandom;
        forever begin
            @(negedge clk);
            if (!reset && calc_cmd_out != 4'd0) begin
                c    = calc_cmd_out;
                a    = calc_data_out;
                have = (bus_q.size() != 0);
                if (have) begin
                    be = bus_q.pop_front();
                    chk("bus_op1", {c, a}, {be.cmd, be.d1});
                end else begin
                    chk("bus_unexpected", 96'(c), 96'(0));
                end
                @(negedge clk);
                b = calc_data_out;
                if (have) chk("bus_op2", {calc_cmd_out, calc_data_out}, {4'd0, be.d2});
                @(negedge clk);
                chk("bus_op_end", {calc_cmd_out, calc_data_out}, 96'(0));
                if (!hang) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    r            = calc_model(c, a, b);
                    resp_drv     = r.code;
                    calc_data_in = r.data;
                    @(negedge clk);
                    resp_drv     = 2'd0;
                    calc_data_in = $urandom;
                end
            end else if (!reset) begin
                chk("bus_idle_data", 96'(calc_data_out), 96'(0));
            end
        end
    end

    // Response monitor: owns rsp_ready, checks hold stability and pops the scoreboard on each handshake.
    initial begin
        bit   held;
        bit   rdy;
        rsp_t snap;
        rsp_t e;
        held      = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (squash) begin
                held      = 1'b0;
                rsp_ready = 1'b0;
                continue;
            end
            if (held)
                chk("rsp_hold", {rsp_valid, rsp_timeout, rsp_code, rsp_data}, {1'b1, snap});
            rdy = !stall && ($urandom_range(0, 3) != 0);
            if (rsp_valid) begin
                if (rdy) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 96'(1), 96'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp", {rsp_timeout, rsp_code, rsp_data}, e);
                    end
                end else begin
                    held = 1'b1;
                    snap = {rsp_timeout, rsp_code, rsp_data};
                end
            end else begin
                held = 1'b0;
            end
            rsp_ready = rdy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rsp_t snap;
        bit   flag;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 4'd0;
        req_data1 = 32'd0;
        req_data2 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 96'(req_ready), 96'(1));
        chk("rst_outputs", {calc_cmd_out, calc_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout, busy, fifo_count}, 96'(0));
        reset = 1'b0;

        // add 1+1
        push_req(4'd1, 32'd1, 32'd1);
        @(negedge clk);
        chk("t1_bus_latency", {calc_cmd_out, calc_data_out}, {4'd1, 32'd1});
        wait_drain("t1_drain");

        // carry out of add
        push_req(4'd1, 32'hFFFF_FFFF, 32'd1);
        wait_drain("t2_drain");

        // null command answered locally
        push_req(4'd0, $urandom, $urandom);
        @(negedge clk);
        chk("t3_local_rsp", {rsp_valid, rsp_code, rsp_data}, {1'b1, 2'd3, 32'd0});
        wait_drain("t3_drain");

        // back-pressure: queue fills while the first response is held
        stall = 1'b1;
        for (int i = 0; i < 5; i++)
            push_req((i % 2 == 0) ? 4'd2 : 4'd5, rand_word(), rand_word());
        repeat (15) @(negedge clk);
        chk("t4_full", {req_ready, fifo_count, rsp_valid}, {1'b0, 3'd4, 1'b1});
        snap = {rsp_timeout, rsp_code, rsp_data};
        repeat (10) @(negedge clk);
        chk("t4_stable", {rsp_valid, rsp_timeout, rsp_code, rsp_data}, {1'b1, snap});
        stall = 1'b0;
        wait_drain("t4_drain");

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_req(pick_cmd(), rand_word(), rand_word());
        end
        wait_drain("rand_drain");

`ifdef CALC1_SEQ_TIMEOUT_EN
        hang  = 1'b1;
        stall = 1'b1;
        push_req(4'd1, 32'd5, 32'd6);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            flag |= rsp_valid;
        end
        chk("t5_no_early_timeout", 96'(flag), 96'(0));
        @(negedge clk);
        chk("t5_timeout_rsp", {rsp_valid, rsp_timeout, rsp_code, rsp_data}, {1'b1, 1'b1, 2'd0, 32'd0});
        stall = 1'b0;
        wait_drain("t5_drain");
        chk("t5_timeout_clear", 96'(rsp_timeout), 96'(0));
`endif

        // stuck command, then reset abandons it along with the queued work
        hang  = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++)
            push_req(4'd1, rand_word(), rand_word());
        flag = 1'b1;
        repeat (100) begin
            @(negedge clk);
            flag &= busy;
        end
        chk("t5_busy_held", 96'(flag), 96'(1));
        chk("t6_queued", 96'(fifo_count), 96'(2));
        squash = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_outputs", {calc_cmd_out, calc_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout, busy, fifo_count}, 96'(0));
        chk("t6_rst_ready", 96'(req_ready), 96'(1));
        exp_q.delete();
        bus_q.delete();
        stray_en = 1'b1;
        @(negedge clk);
        stray_en = 1'b0;
        flag = 1'b1;
        repeat (5) begin
            @(negedge clk);
            flag &= !rsp_valid && !busy && (fifo_count == 3'd0);
        end
        chk("t6_late_resp_ignored", 96'(flag), 96'(1));
        squash = 1'b0;
        hang   = 1'b0;
        stall  = 1'b0;

        push_req(4'd2, 32'd10, 32'd3);
        wait_drain("recover_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
